// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier with valid/ready on both sides.
// Retires DIGITS_PER_CYCLE Booth digits per RUN cycle. A per-operation mode
// bit selects a signed or unsigned product.
module booth_r4_seq_mult #(
  parameter int N                = 32,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   op1,
  input  logic [N-1:0]   op2,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out,
  output logic           busy
);

  localparam int K  = DIGITS_PER_CYCLE;
  localparam int W  = N + 2;          // extended operand width
  localparam int D  = W / 2;          // Booth digits needed
  localparam int C  = (D + K - 1) / K;// RUN cycles
  localparam int PW = 2 * C * K;      // multiplier width incl. padding digits
  localparam int AW = 2 * N + 2;      // accumulator width
  localparam int CW = $clog2(C * K + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'((C - 1) * K);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   accept;
  logic                   last_run;
  logic signed [AW-1:0]   mcand;     // multiplicand, pre-shifted to current digit weight
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_nxt;
  logic        [PW:0]     mplr;      // multiplier with m[-1] = 0 at bit 0
  logic        [CW-1:0]   dcnt;
  logic signed [AW-1:0]   op1_ext;
  logic        [PW-1:0]   op2_ext;

  // Booth radix-4 digit decode to a partial product at accumulator width.
  function automatic logic signed [AW-1:0] booth_pp(input logic [2:0] trip,
                                                    input logic signed [AW-1:0] m);
    case (trip)
      3'b001, 3'b010: return m;
      3'b011:         return m <<< 1;
      3'b100:         return -(m <<< 1);
      3'b101, 3'b110: return -m;
      default:        return '0;
    endcase
  endfunction

  assign op1_ext  = {{(AW-N){is_signed & op1[N-1]}}, op1};
  assign op2_ext  = {{(PW-N){is_signed & op2[N-1]}}, op2};
  assign accept   = in_valid & in_ready;
  assign last_run = (dcnt == LAST_CNT);

  // Sum this cycle's K partial products into the accumulator.
  always_comb begin
    acc_nxt = acc;
    for (int j = 0; j < K; j++) begin
      acc_nxt = acc_nxt + (booth_pp(mplr[2*j +: 3], mcand) <<< (2 * j));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake/status outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_run) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate digits in RUN, register product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      dcnt  <= '0;
      out   <= '0;
    end else if (accept) begin
      mcand <= op1_ext;
      mplr  <= {op2_ext, 1'b0};
      acc   <= '0;
      dcnt  <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nxt;
      mplr  <= mplr >> (2 * K);
      mcand <= mcand <<< (2 * K);
      dcnt  <= dcnt + CW'(K);
      if (last_run) out <= acc_nxt[2*N-1:0];
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed and randomised checks of booth_r4_seq_mult across several
// widths and digits-per-cycle settings.
module tb_booth_r4_seq_mult;

  logic        clk;
  logic        rst_n;
  logic [4:0]  iv;
  logic [4:0]  ordy;
  logic [4:0]  ir;
  logic [4:0]  ov;
  logic [4:0]  bz;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        is_signed;
  logic [15:0] o0, o1;
  logic [63:0] o2, o3, o4;

  int checks   = 0;
  int failures = 0;

  booth_r4_seq_mult #(.N(8),  .DIGITS_PER_CYCLE(1))  u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .op1(op1[7:0]), .op2(op2[7:0]), .is_signed(is_signed), .out_valid(ov[0]), .out_ready(ordy[0]), .out(o0), .busy(bz[0]));
  booth_r4_seq_mult #(.N(8),  .DIGITS_PER_CYCLE(2))  u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .op1(op1[7:0]), .op2(op2[7:0]), .is_signed(is_signed), .out_valid(ov[1]), .out_ready(ordy[1]), .out(o1), .busy(bz[1]));
  booth_r4_seq_mult #(.N(32), .DIGITS_PER_CYCLE(1))  u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .op1(op1), .op2(op2), .is_signed(is_signed), .out_valid(ov[2]), .out_ready(ordy[2]), .out(o2), .busy(bz[2]));
  booth_r4_seq_mult #(.N(32), .DIGITS_PER_CYCLE(3))  u3 (.clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .op1(op1), .op2(op2), .is_signed(is_signed), .out_valid(ov[3]), .out_ready(ordy[3]), .out(o3), .busy(bz[3]));
  booth_r4_seq_mult #(.N(32), .DIGITS_PER_CYCLE(17)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]),
    .op1(op1), .op2(op2), .is_signed(is_signed), .out_valid(ov[4]), .out_ready(ordy[4]), .out(o4), .busy(bz[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] get_out(input int idx);
    case (idx)
      0:       return {48'b0, o0};
      1:       return {48'b0, o1};
      2:       return o2;
      3:       return o3;
      default: return o4;
    endcase
  endfunction

  // Reference product via native 64-bit multiply.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int n);
    logic [63:0] ea, eb, p;
    if (n == 8) begin
      ea = s ? {{56{a[7]}}, a[7:0]} : {56'b0, a[7:0]};
      eb = s ? {{56{b[7]}}, b[7:0]} : {56'b0, b[7:0]};
    end else begin
      ea = s ? {{32{a[31]}}, a} : {32'b0, a};
      eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    end
    p = ea * eb;
    return (n == 8) ? (p & 64'hFFFF) : p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one operation and return #1 after the accepting edge; inputs are
  // then scrambled to show they do not affect the result.
  task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    op1 = a; op2 = b; is_signed = s; iv[idx] = 1'b1;
    chk("in_ready_before_accept", {63'b0, ir[idx]}, 64'd1);
    @(posedge clk); #1;
    iv[idx] = 1'b0;
    op1 = $urandom; op2 = $urandom; is_signed = 1'($urandom);
  endtask

  // Count edges until out_valid, then check latency and product.
  task automatic wait_result(input int idx, input logic [63:0] exp, input int exp_lat, input string tag);
    int lat = 0;
    while (!ov[idx] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_product"}, get_out(idx), exp);
  endtask

  task automatic ack(input int idx, input string tag);
    ordy[idx] = 1'b1;
    @(posedge clk); #1;
    ordy[idx] = 1'b0;
    chk({tag, "_out_valid_drop"}, {63'b0, ov[idx]}, 64'd0);
    chk({tag, "_in_ready_back"}, {63'b0, ir[idx]}, 64'd1);
  endtask

  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input int exp_lat, input string tag);
    issue(idx, a, b, s);
    wait_result(idx, exp, exp_lat, tag);
    ack(idx, tag);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          lats[3];
    int          cnts[3];
    lats = '{17, 6, 1};
    cnts = '{100, 200, 300};

    rst_n = 1'b0; iv = '0; ordy = '0;
    op1 = 32'd2; op2 = 32'd3; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("reset_out_valid", {63'b0, ov[i]}, 64'd0);
      chk("reset_in_ready",  {63'b0, ir[i]}, 64'd1);
      chk("reset_busy",      {63'b0, bz[i]}, 64'd0);
      chk("reset_out",       get_out(i), 64'd0);
    end

    // in_valid held high through reset release: accepted on first edge.
    iv[0] = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("release_accept_busy",   {63'b0, bz[0]}, 64'd1);
    chk("release_accept_ready",  {63'b0, ir[0]}, 64'd0);
    wait_result(0, 64'd6, 5, "release_2x3");
    ack(0, "release_2x3");

    // N=8, one digit per cycle.
    run_op(0, 32'h80, 32'h80, 1'b1, 64'h4000, 5, "k1_s_80x80");
    run_op(0, 32'hFF, 32'hFF, 1'b0, 64'hFE01, 5, "k1_u_FFxFF");
    run_op(0, 32'hFF, 32'hFF, 1'b1, 64'h0001, 5, "k1_s_FFxFF");

    // N=8, two digits per cycle.
    run_op(1, 32'h7F, 32'h80, 1'b1, 64'hC080, 3, "k2_s_7Fx80");
    run_op(1, 32'h00, 32'hA5, 1'b1, 64'h0000, 3, "k2_s_00xA5");

    // Backpressure in DONE: 5 x -3 = -15.
    issue(1, 32'h05, 32'hFD, 1'b1);
    wait_result(1, 64'hFFF1, 3, "bp_5xm3");
    op1 = 32'h02; op2 = 32'h02; is_signed = 1'b0; iv[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid_held", {63'b0, ov[1]}, 64'd1);
      chk("bp_out_held",       get_out(1), 64'hFFF1);
      chk("bp_in_ready_low",   {63'b0, ir[1]}, 64'd0);
    end
    @(negedge clk);
    iv[1] = 1'b0;
    ack(1, "bp_release");
    chk("bp_out_kept_in_idle", get_out(1), 64'hFFF1);
    @(posedge clk); #1;
    chk("bp_no_overlap_accept", {63'b0, bz[1]}, 64'd0);

    // Asynchronous reset mid-RUN abandons the operation.
    issue(0, 32'h7F, 32'h7F, 1'b1);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {63'b0, ov[0]}, 64'd0);
    chk("rst_mid_in_ready",  {63'b0, ir[0]}, 64'd1);
    chk("rst_mid_busy",      {63'b0, bz[0]}, 64'd0);
    chk("rst_mid_out",       get_out(0), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      chk("rst_mid_no_product", {63'b0, ov[0]}, 64'd0);
    end
    run_op(0, 32'd3, 32'd5, 1'b0, 64'd15, 5, "after_rst_3x5");

    // N=32 corner values.
    run_op(3, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 6, "n32_s_min_sq");
    run_op(3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 6, "n32_u_max_sq");
    run_op(4, 32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000, 1, "n32_s_max_min");

    // Randomised sweep against the reference model.
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < cnts[k]; t++) begin
        a = $urandom; b = $urandom; s = 1'($urandom);
        if (t == 0) begin a = 32'hFFFFFFFF; b = 32'h80000000; end
        run_op(k + 2, a, b, s, ref_mul(a, b, s, 32), lats[k], "n32_sweep");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
